// File: rtl/l2_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_pkg
// Description : Shared widths, latency default and pipeline-entry type for
//               the l2_mem_pipe read pipeline.
//               Optional feature macro: L2_MEM_WR_FWD_EN (in-flight write
//               forwarding), used by l2_mem_stage and l2_mem_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_mem_pkg;

   localparam int DEF_ADDR_W  = 16;              // byte address width
   localparam int DEF_DATA_W  = 16;              // data word width
   localparam int DEF_LATENCY = 4;               // read latency, 1..8
   localparam int DEF_IDX_W   = DEF_ADDR_W - 1;  // word index width

   // One slot of the read pipeline: a read's valid flag, its word-aligned
   // byte address and the data it will return.
   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } pipe_entry_t;

   // Byte address with bit 0 cleared, i.e. the address of the word.
   function automatic logic [DEF_ADDR_W-1:0] word_addr(input logic [DEF_ADDR_W-1:0] a);
      return {a[DEF_ADDR_W-1:1], 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_stage
// Description : One entry of the read pipeline. Registers the incoming entry
//               and, when L2_MEM_WR_FWD_EN is defined, replaces its data with
//               a concurrent write to the same word index.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_stage
   import l2_mem_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,        // asynchronous, active low
   input  pipe_entry_t          entry_in,
`ifdef L2_MEM_WR_FWD_EN
   input  logic                 fwd_en,
   input  logic [DEF_IDX_W-1:0] fwd_idx,
   input  logic [DEF_DATA_W-1:0] fwd_data,
`endif
   output pipe_entry_t          entry_out
);

   pipe_entry_t next_entry;

   // Entry to load at the next edge, with write data substituted on a hit.
   always_comb begin
      next_entry = entry_in;
`ifdef L2_MEM_WR_FWD_EN
      if (fwd_en && entry_in.valid && (entry_in.addr[DEF_ADDR_W-1:1] == fwd_idx)) begin
         next_entry.data = fwd_data;
      end
`endif
   end

   // Pipeline register; reset drops whatever read it holds.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry_out <= '0;
      end else begin
         entry_out <= next_entry;
      end
   end

endmodule
`default_nettype wire

// File: rtl/l2_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : l2_mem_pipe
// Description : Single-port word memory with a fixed-latency, fully pipelined
//               read path. Reads sample the array at issue and ride a
//               LATENCY-deep chain of l2_mem_stage entries; the last entry
//               drives the outputs. Writes land at the issuing edge.
//               Optional feature macro: L2_MEM_WR_FWD_EN - a write updates
//               the data of in-flight reads to the same word.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_pipe
   import l2_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,   // must match the package entry width
   parameter int DATA_W  = DEF_DATA_W,   // must match the package entry width
   parameter int LATENCY = DEF_LATENCY   // 1..8, keeps inflight within 4 bits
)(
   input  logic              clk,
   input  logic              rst,        // asynchronous, active low
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] addr_out,
   output logic [3:0]        inflight
);

   localparam int IDX_W = ADDR_W - 1;
   localparam int DEPTH = 1 << IDX_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              rd_issue;
   logic              wr_issue;
   logic              rd_return;
   logic [DATA_W-1:0] last_data;
   logic [ADDR_W-1:0] last_addr;
   pipe_entry_t       head;
   pipe_entry_t       chain [LATENCY+1];

   assign idx       = addr[ADDR_W-1:1];
   assign rd_issue  = enable & ~wr;
   // Writes are blocked while reset is held so enable is truly ignored.
   assign wr_issue  = enable & wr & rst;
   assign rd_return = chain[LATENCY].valid;

   // Array write at the issuing edge; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_issue) begin
         mem[idx] <= data_in;
      end
   end

   // New pipeline entry: the read's word address and the array data now.
   always_comb begin
      head       = '0;
      head.valid = rd_issue;
      head.addr  = word_addr(addr);
      head.data  = mem[idx];
   end

   assign chain[0] = head;

   generate
      for (genvar g = 0; g < LATENCY; g++) begin : g_stage
         l2_mem_stage u_stage (
            .clk       (clk),
            .rst       (rst),
            .entry_in  (chain[g]),
`ifdef L2_MEM_WR_FWD_EN
            .fwd_en    (wr_issue),
            .fwd_idx   (idx),
            .fwd_data  (data_in),
`endif
            .entry_out (chain[g+1])
         );
      end
   endgenerate

   // Remember the last returned word so outputs hold between returns.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_data <= '0;
         last_addr <= '0;
      end else if (rd_return) begin
         last_data <= chain[LATENCY].data;
         last_addr <= chain[LATENCY].addr;
      end
   end

   // Outstanding-read counter: up on issue, down on return.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 4'd0;
      end else begin
         case ({rd_issue, rd_return})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   assign data_valid = rd_return;
   assign data_out   = rd_return ? chain[LATENCY].data : last_data;
   assign addr_out   = rd_return ? chain[LATENCY].addr : last_addr;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_mem_pipe
// Description : Self-checking bench for l2_mem_pipe. A queue of outstanding
//               reads, each aging one cycle per clock, predicts returns;
//               directed scenarios plus a random run are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_mem_pipe;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        wr = 1'b0;
   logic [15:0] addr = '0;
   logic [15:0] data_in = '0;
   wire  [15:0] data_out;
   wire         data_valid;
   wire  [15:0] addr_out;
   wire  [3:0]  inflight;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   l2_mem_pipe #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .wr         (wr),
      .addr       (addr),
      .data_in    (data_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .addr_out   (addr_out),
      .inflight   (inflight)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int          age;
      logic [15:0] addr;
      logic [15:0] data;
   } rd_t;

   logic [15:0] model_mem [0:32767];
   rd_t         rq [$];
   logic        exp_valid;
   logic [15:0] exp_data, exp_addr, hold_data, hold_addr;
   logic [3:0]  exp_inflight;

   function automatic void model_reset();
      rq.delete();
      hold_data    = '0;
      hold_addr    = '0;
      exp_valid    = 1'b0;
      exp_data     = '0;
      exp_addr     = '0;
      exp_inflight = '0;
   endfunction

   // One clock edge: a read is returned once it has aged LAT cycles.
   function automatic void model_edge(logic en, logic w, logic [15:0] a, logic [15:0] d);
      rd_t e;
      if (rq.size() > 0 && rq[0].age == LAT) void'(rq.pop_front());
      foreach (rq[i]) rq[i].age++;
      if (en && w) begin
`ifdef L2_MEM_WR_FWD_EN
         foreach (rq[i]) if (rq[i].addr[15:1] == a[15:1]) rq[i].data = d;
`endif
         model_mem[a[15:1]] = d;
      end else if (en) begin
         e.age  = 1;
         e.addr = {a[15:1], 1'b0};
         e.data = model_mem[a[15:1]];
         rq.push_back(e);
      end
      exp_valid = (rq.size() > 0) && (rq[0].age == LAT);
      if (exp_valid) begin
         hold_data = rq[0].data;
         hold_addr = rq[0].addr;
      end
      exp_data     = hold_data;
      exp_addr     = hold_addr;
      exp_inflight = 4'(rq.size());
   endfunction

   // Drive one request, clock it, update the model, settle past the edge.
   task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
      enable  = en;
      wr      = w;
      addr    = a;
      data_in = d;
      @(posedge clk);
      if (rst) model_edge(en, w, a, d);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2;
      checks++;
      if ({data_valid, data_out, addr_out, inflight} !== 37'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b d=%h a=%h n=%0d want all zero", data_valid, data_out, addr_out, inflight);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      int lat_seen = -1;
      step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
      step(1'b1, 1'b0, 16'h0010, 16'h0000);
      checks++;
      if (inflight !== 4'd1) begin
         errors++;
         $display("FAIL basic_inflight_issue: got %0d want 1", inflight);
      end
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         checks++;
         if ({data_valid, data_out, addr_out, inflight} !== {exp_valid, exp_data, exp_addr, exp_inflight}) begin
            errors++;
            $display("FAIL basic_model k=%0d: got v=%b d=%h a=%h n=%0d want v=%b d=%h a=%h n=%0d", k, data_valid, data_out, addr_out, inflight, exp_valid, exp_data, exp_addr, exp_inflight);
         end
         if (data_valid && lat_seen < 0) begin
            lat_seen = k + 2;
            checks++;
            if (data_out !== 16'hBEEF || addr_out !== 16'h0010 || inflight !== 4'd1) begin
               errors++;
               $display("FAIL basic_return: got d=%h a=%h n=%0d want d=BEEF a=0010 n=1", data_out, addr_out, inflight);
            end
         end
      end
      checks++;
      if (lat_seen != LAT) begin
         errors++;
         $display("FAIL basic_latency: got %0d want %0d", lat_seen, LAT);
      end
      checks++;
      if (inflight !== 4'd0) begin
         errors++;
         $display("FAIL basic_inflight_end: got %0d want 0", inflight);
      end
   endtask

   task automatic test_odd_addr();
      logic [15:0] v = 16'($urandom);
      int seen = 0;
      step(1'b1, 1'b1, 16'h0010, v);
      step(1'b1, 1'b0, 16'h0011, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         if (data_valid) begin
            seen++;
            checks++;
            if (addr_out !== 16'h0010 || data_out !== v) begin
               errors++;
               $display("FAIL odd_addr: got a=%h d=%h want a=0010 d=%h", addr_out, data_out, v);
            end
         end
      end
      checks++;
      if (seen != 1) begin
         errors++;
         $display("FAIL odd_addr_count: got %0d returns want 1", seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got [$];
      int first = -1, last = -1, peak = 0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'(2 * i), 16'(i + 1));
      for (int k = 0; k < 10; k++) begin
         if (k < 4) step(1'b1, 1'b0, 16'(2 * k), 16'h0000);
         else       step(1'b0, 1'b0, 16'h0000, 16'h0000);
         checks++;
         if ({data_valid, data_out, addr_out, inflight} !== {exp_valid, exp_data, exp_addr, exp_inflight}) begin
            errors++;
            $display("FAIL b2b_model k=%0d: got v=%b d=%h a=%h n=%0d want v=%b d=%h a=%h n=%0d", k, data_valid, data_out, addr_out, inflight, exp_valid, exp_data, exp_addr, exp_inflight);
         end
         if (int'(inflight) > peak) peak = int'(inflight);
         if (data_valid) begin
            got.push_back(data_out);
            if (first < 0) first = k;
            last = k;
         end
      end
      checks++;
      if (peak != 4) begin
         errors++;
         $display("FAIL b2b_peak: got %0d want 4", peak);
      end
      checks++;
      if (got.size() != 4 || last - first != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d returns over %0d cycles want 4 over 4", got.size(), last - first + 1);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== 16'(i + 1)) begin
               errors++;
               $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], 16'(i + 1));
            end
         end
      end
   endtask

   task automatic test_fwd();
      logic [15:0] want;
      logic [15:0] got = 16'h0000;
`ifdef L2_MEM_WR_FWD_EN
      want = 16'h2222;
`else
      want = 16'h1111;
`endif
      step(1'b1, 1'b1, 16'h0020, 16'h1111);
      step(1'b1, 1'b0, 16'h0020, 16'h0000);
      step(1'b1, 1'b1, 16'h0020, 16'h2222);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         if (data_valid) got = data_out;
      end
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL fwd_value: got %h want %h", got, want);
      end
   endtask

   task automatic test_raw();
      logic [15:0] a = 16'($urandom_range(0, 127));
      logic [15:0] v = 16'($urandom);
      logic [15:0] got = 16'h0000;
      step(1'b1, 1'b1, a, v);
      step(1'b1, 1'b0, a, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         if (data_valid) got = data_out;
      end
      checks++;
      if (got !== v) begin
         errors++;
         $display("FAIL raw_value: got %h want %h", got, v);
      end
   endtask

   task automatic test_reset_inflight();
      int stray = 0;
      step(1'b1, 1'b1, 16'h0030, 16'hA0A0);
      step(1'b1, 1'b1, 16'h0032, 16'hB1B1);
      step(1'b1, 1'b1, 16'h0034, 16'hC2C2);
      step(1'b1, 1'b0, 16'h0030, 16'h0000);
      step(1'b1, 1'b0, 16'h0032, 16'h0000);
      step(1'b1, 1'b0, 16'h0034, 16'h0000);
      // Reset mid-cycle while a write request is presented.
      enable  = 1'b1;
      wr      = 1'b1;
      addr    = 16'h0030;
      data_in = 16'hDEAD;
      rst     = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({data_valid, data_out, addr_out, inflight} !== 37'd0) begin
         errors++;
         $display("FAIL rst_async: got v=%b d=%h a=%h n=%0d want all zero", data_valid, data_out, addr_out, inflight);
      end
      @(posedge clk); #1;
      rst    = 1'b1;
      enable = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b0, 16'h0000, 16'h0000);
         if (data_valid || inflight !== 4'd0) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL rst_discard: got %0d cycles with activity want 0", stray);
      end
      for (int k = 0; k < 9; k++) begin
         if (k < 3) step(1'b1, 1'b0, 16'(16'h0030 + 2 * k), 16'h0000);
         else       step(1'b0, 1'b0, 16'h0000, 16'h0000);
         checks++;
         if ({data_valid, data_out, addr_out, inflight} !== {exp_valid, exp_data, exp_addr, exp_inflight}) begin
            errors++;
            $display("FAIL rst_survive k=%0d: got v=%b d=%h a=%h n=%0d want v=%b d=%h a=%h n=%0d", k, data_valid, data_out, addr_out, inflight, exp_valid, exp_data, exp_addr, exp_inflight);
         end
      end
   endtask

   task automatic test_write_burst();
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 16'($urandom_range(0, 127)), 16'($urandom));
         checks++;
         if (data_valid !== 1'b0 || inflight !== 4'd0) begin
            errors++;
            $display("FAIL wr_burst k=%0d: got v=%b n=%0d want v=0 n=0", k, data_valid, inflight);
         end
      end
   endtask

   task automatic test_random();
      logic en, w;
      for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 16'(2 * i), 16'($urandom));
      for (int k = 0; k < 400 + LAT + 2; k++) begin
         en = (k < 400) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
         w  = 1'($urandom_range(0, 2) == 0);
         step(en, w, 16'($urandom_range(0, 127)), 16'($urandom));
         checks++;
         if ({data_valid, data_out, addr_out, inflight} !== {exp_valid, exp_data, exp_addr, exp_inflight}) begin
            errors++;
            $display("FAIL random k=%0d: got v=%b d=%h a=%h n=%0d want v=%b d=%h a=%h n=%0d", k, data_valid, data_out, addr_out, inflight, exp_valid, exp_data, exp_addr, exp_inflight);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_odd_addr();
      test_back_to_back();
      test_fwd();
      test_raw();
      test_reset_inflight();
      test_write_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l2_mem_pipe.md
L2_MEM_PIPE -- requirements
Module: l2_mem_pipe

Interface
REQ-001 Parameter ADDR_W, default 16, byte address width.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter LATENCY, default 4, read latency in cycles; legal range 1..8.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  request strobe, sampled each cycle.
REQ-007 wr  input  1  1 = write, 0 = read; ignored when enable=0.
REQ-008 addr  input  ADDR_W  byte address; bit 0 ignored, word index = addr[ADDR_W-1:1].
REQ-009 data_in  input  DATA_W  write data.
REQ-010 data_out  output  DATA_W  read data; valid only when data_valid=1.
REQ-011 data_valid  output  1  one-cycle pulse per completed read.
REQ-012 addr_out  output  ADDR_W  address of the read being returned, bit 0 forced 0.
REQ-013 inflight  output  4  count of reads issued but not yet returned.

Function
REQ-014 Storage SHALL be a single-port array of 2^(ADDR_W-1) words of DATA_W bits.
REQ-015 Write (enable=1, wr=1): the word SHALL be written at that clock edge; no data_valid SHALL be produced.
REQ-016 Read (enable=1, wr=0): array data and address SHALL be captured at issue and carried through a LATENCY-deep shift pipeline.
REQ-017 A read issued at edge N SHALL assert data_valid, data_out and addr_out during the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles after issue.
REQ-018 Reads SHALL be fully pipelined: one new read accepted every cycle, returned in issue order, no stall and no back-pressure.
REQ-019 Requests SHALL be processed one per cycle only, with reads and writes mutually exclusive by wr.
REQ-020 When data_valid=0, data_out and addr_out SHALL hold their last returned values.
REQ-021 inflight SHALL add 1 on read issue and subtract 1 on read return; both in the same cycle SHALL leave it unchanged.
REQ-022 inflight SHALL never exceed LATENCY.
REQ-023 Read-after-write to the same word on the next cycle SHALL return the new data.
REQ-024 Read and write to the same word in one cycle is impossible: single port, wr selects one.
REQ-025 A write arriving while earlier reads to that word are in flight SHALL follow REQ-034 (macro set) or REQ-035 (macro clear).

Reset
REQ-026 On rst=0, immediately and independent of clk: all pipeline valid bits, data_valid and inflight SHALL go to 0.
REQ-027 On rst=0: data_out and addr_out SHALL go to 0.
REQ-028 Array contents SHALL NOT be cleared by reset.
REQ-029 Reads in flight when reset asserts SHALL be discarded and never returned.
REQ-030 enable SHALL be ignored while rst=0.
REQ-031 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro L2_MEM_WR_FWD_EN SHALL select in-flight write forwarding.
REQ-033 The default build has the macro undefined.
REQ-034 Defined: a write SHALL replace the carried data of every in-flight read to the same word index, so those reads return the written value.
REQ-035 Undefined: in-flight reads SHALL return the data sampled at issue, and the forwarding comparators SHALL be absent.

Structure
REQ-036 Package l2_mem_pkg SHALL hold ADDR_W/DATA_W/LATENCY defaults, the word-index width constant, and the pipeline-entry struct type {valid, addr, data}.
REQ-037 One sub-module, l2_mem_stage, SHALL implement a single pipeline entry (register plus optional forward compare), instantiated LATENCY times by generate.

Verification
REQ-038 After reset, write 0xBEEF at 0x0010, then read 0x0010 -> data_valid exactly 4 cycles later, data_out=0xBEEF, addr_out=0x0010, inflight 1 then 0.
REQ-039 Read 0x0011 -> addr_out=0x0010 and the same word as 0x0010 is returned.
REQ-040 Back-to-back reads of 0x0000, 0x0002, 0x0004, 0x0006 preloaded with 1, 2, 3, 4 -> four consecutive data_valid cycles in order 1, 2, 3, 4; inflight peaks at 4.
REQ-041 Read 0x0020 (holding 0x1111), then write 0x2222 to 0x0020 next cycle -> returned value 0x2222 with L2_MEM_WR_FWD_EN defined, 0x1111 without.
REQ-042 Issue 3 reads, then assert rst=0 for 1 cycle after 2 cycles -> no data_valid ever follows, inflight=0 immediately, and array data survives a later read.
REQ-043 Hold enable=1 with wr=1 for 10 cycles -> data_valid stays 0 and inflight stays 0 throughout.
